multicycle_control_unit: RTL and testbench
==========================================

// Module: multicycle_control_unit
// PURPOSE
//  Multi-cycle successor to the single-cycle control unit: sequences FETCH/DECODE/EXEC/WRITEBACK for 16-bit A/C instructions.
//  Adds parametrised widths, valid/ready handshakes to instruction and data memory, M-operand reads, and conditional jumps.
//  Sits between the instruction/data memory ports, the ALU and the A/D register file.
// PARAMETERS
//  WIDTH     16  data/instruction width (>=16); instruction fields at fixed bit positions below
//  PC_WIDTH  16  program counter width; PC wraps modulo 2^PC_WIDTH
//  TRAP_VEC  0   PC loaded on an illegal instruction (ILLEGAL_TRAP_EN only)
// PORTS
//  clk          in   1         single clock, rising edge
//  rst          in   1         asynchronous, active-low reset
//  instr        in   WIDTH     instruction word, sampled when instr_req&&instr_valid
//  instr_valid  in   1         instruction memory data ready
//  instr_req    out  1         instruction fetch request
//  pc           out  PC_WIDTH  current program counter
//  reg_a_in     in   WIDTH     current A register value
//  reg_d_in     in   WIDTH     current D register value
//  alu_result   in   WIDTH     combinational ALU result for x,y,opcode
//  x, y         out  WIDTH     ALU operands
//  opcode       out  7         {a, comp[5:0]} = instr[12:6]
//  instr_type   out  1         latched instr[15]: 0=A-type, 1=C-type
//  reg_a_en     out  1         one-cycle A write strobe
//  reg_d_en     out  1         one-cycle D write strobe
//  reg_wdata    out  WIDTH     write data for A/D
//  mem_req      out  1         data memory request, held until mem_ready
//  mem_we       out  1         1=write, 0=read; valid while mem_req
//  mem_addr     out  WIDTH     data address
//  mem_wdata    out  WIDTH     write data
//  mem_rdata    in   WIDTH     read data, valid when mem_ready on a read
//  mem_ready    in   1         completes the current mem_req
//  set_pc       out  1         one-cycle strobe when a jump is taken
//  illegal      out  1         sticky illegal-instruction flag (0 when macro absent)
// BEHAVIOUR
//  - Reset (rst=0): immediately state=FETCH, pc=0, every output 0, IR/MDR/latches 0; in-flight mem_req dropped.
//  - Decode: A-type = instr[15]==0; C-type = 111 a cccccc ddd jjj.
//    Dest bits: d[5]=A, d[4]=D, d[3]=M. Jump bits: j[2]=LT, j[1]=EQ, j[0]=GT.
//  - FETCH: instr_req=1 until instr_valid; latch IR -> DECODE. instr is ignored while instr_req=0.
//  - DECODE, A-type: reg_a_en=1, reg_wdata=IR with bit15 cleared; pc+=1 -> FETCH (2 cycles, no waits).
//  - DECODE, C-type: latch A_cap=reg_a_in. If a=1: mem_req=1, mem_we=0, mem_addr=reg_a_in -> MEM_RD; else -> EXEC.
//  - MEM_RD: hold request until mem_ready; latch MDR=mem_rdata -> EXEC.
//  - EXEC: x=reg_d_in, y=(a ? MDR : reg_a_in), opcode=IR[12:6]; latch R=alu_result -> WB. x/y/opcode are held through WB.
//  - WB: reg_wdata=R, reg_a_en=d[5], reg_d_en=d[4].
//    Jump taken = (j[2]&R<0) | (j[1]&R==0) | (j[0]&R>0) (R signed).
//    If taken: set_pc=1, pc=A_cap[PC_WIDTH-1:0]; else pc+=1.
//    If d[3]: mem_req=1, mem_we=1, mem_addr=A_cap, mem_wdata=R -> MEM_WR; else -> FETCH.
//  - MEM_WR: hold until mem_ready -> FETCH.
//  - Latency (zero wait states): C no-M 4 cycles; +1 for an M read, +1 for an M write.
//  - Simultaneous A write and jump/M write: target and address use pre-write A_cap. pc=2^PC_WIDTH-1 increments to 0.
//  - Strobes (reg_*_en, set_pc) are exactly one cycle; mem_req/instr_req never drop before ready/valid.
//  - Undefined C-type prefix (instr[14:13]!=11) is executed as normal C-type when the macro is absent.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined:
//   - C-type with instr[14:13]!=11 in DECODE: no writes, no memory access.
//   - illegal=1 (sticky until reset), set_pc=1, pc=TRAP_VEC -> FETCH.
//  Undefined: no check; illegal tied 0.
// TESTING
//  1 rst=0 during MEM_RD wait -> mem_req, outputs, pc go 0 without clock; after release, FETCH at pc=0.
//  2 instr=16'h0003 -> reg_a_en 1 cycle, reg_wdata=3, pc 0->1, instr_req again after 2 cycles.
//  3 A=2, D=3, instr=1110_000010_010_000, alu_result=5 -> x=3, y=2, opcode=7'b0000010; reg_d_en with wdata=5; 4 cycles.
//  4 instr=1111_000010_001_000, mem_ready 3 cycles late, mem_rdata=4, alu_result=7 -> y=4; write addr=2, data=7 held to ready.
//  5 A=2, alu_result=-5: jjj=100 -> set_pc, pc=2; jjj=001 -> no set_pc, pc+1; pc=16'hFFFF A-type -> pc=0.
//  6 ILLEGAL_TRAP_EN, instr=16'h8000 -> illegal=1, pc=TRAP_VEC, no reg/mem strobes; absent -> executes as C-type.

Source files
------------

// File: rtl/multicycle_control_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : multicycle_control_unit_if                                      |
// | Brief    : Bus bundle around the multi-cycle control unit: instruction   |
// |            fetch handshake, data-memory handshake, ALU operand/result     |
// |            path and A/D register-file ports.                              |
// |            master = control unit, slave = memories/ALU/register file.    |
// | Revision : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
interface multicycle_control_unit_if #(
  parameter int WIDTH    = 16,
  parameter int PC_WIDTH = 16
);

  // Instruction memory
  logic [WIDTH-1:0]    instr;
  logic                instr_valid;
  logic                instr_req;
  logic [PC_WIDTH-1:0] pc;

  // Register file and ALU
  logic [WIDTH-1:0]    reg_a_in;
  logic [WIDTH-1:0]    reg_d_in;
  logic [WIDTH-1:0]    alu_result;
  logic [WIDTH-1:0]    x;
  logic [WIDTH-1:0]    y;
  logic [6:0]          opcode;
  logic                instr_type;
  logic                reg_a_en;
  logic                reg_d_en;
  logic [WIDTH-1:0]    reg_wdata;

  // Data memory
  logic                mem_req;
  logic                mem_we;
  logic [WIDTH-1:0]    mem_addr;
  logic [WIDTH-1:0]    mem_wdata;
  logic [WIDTH-1:0]    mem_rdata;
  logic                mem_ready;

  // Control flow / status
  logic                set_pc;
  logic                illegal;

  modport master (
    input  instr, instr_valid, reg_a_in, reg_d_in, alu_result, mem_rdata, mem_ready,
    output instr_req, pc, x, y, opcode, instr_type, reg_a_en, reg_d_en, reg_wdata,
           mem_req, mem_we, mem_addr, mem_wdata, set_pc, illegal
  );

  modport slave (
    output instr, instr_valid, reg_a_in, reg_d_in, alu_result, mem_rdata, mem_ready,
    input  instr_req, pc, x, y, opcode, instr_type, reg_a_en, reg_d_en, reg_wdata,
           mem_req, mem_we, mem_addr, mem_wdata, set_pc, illegal
  );

endinterface
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : multicycle_control_unit                                         |
// | Brief    : Multi-cycle FETCH/DECODE/EXEC/WRITEBACK sequencer for 16-bit    |
// |            A/C instructions with valid/ready instruction and data memory  |
// |            handshakes, M-operand reads/writes and conditional jumps.      |
// |            Optional macro ILLEGAL_TRAP_EN: traps C-type words whose       |
// |            instr[14:13] prefix is not 11 to TRAP_VEC and raises a sticky  |
// |            illegal flag; without it such words execute as normal C-type.  |
// |            The bus interface instance must use the same WIDTH/PC_WIDTH.   |
// | Revision : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module multicycle_control_unit #(
  parameter int                  WIDTH    = 16,
  parameter int                  PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] TRAP_VEC = '0
) (
  input wire                        clk,
  input wire                        rst_n,
  multicycle_control_unit_if.master cu_bus
);

  // State encoding
  localparam logic [2:0] c_FETCH  = 3'd0;
  localparam logic [2:0] c_DECODE = 3'd1;
  localparam logic [2:0] c_MEM_RD = 3'd2;
  localparam logic [2:0] c_EXEC   = 3'd3;
  localparam logic [2:0] c_WB     = 3'd4;
  localparam logic [2:0] c_MEM_WR = 3'd5;

  localparam logic [PC_WIDTH-1:0] c_PC_ONE    = PC_WIDTH'(1);
  localparam logic [WIDTH-1:0]    c_BIT15_CLR = ~(WIDTH'(1) << 15);

  // Architectural / sequencing registers
  logic [2:0]          state_q, state_d;
  logic                run_q;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0]    ir_q, ir_d;      // instruction register
  logic [WIDTH-1:0]    mdr_q, mdr_d;    // memory data register (M operand)
  logic [WIDTH-1:0]    acap_q, acap_d;  // A value captured at decode
  logic [WIDTH-1:0]    r_q, r_d;        // ALU result latched in EXEC
  logic [WIDTH-1:0]    xh_q, xh_d;      // ALU operands held through WB
  logic [WIDTH-1:0]    yh_q, yh_d;

  // Combinational output values
  logic                w_instr_req;
  logic [WIDTH-1:0]    w_x;
  logic [WIDTH-1:0]    w_y;
  logic [6:0]          w_opcode;
  logic                w_reg_a_en;
  logic                w_reg_d_en;
  logic [WIDTH-1:0]    w_reg_wdata;
  logic                w_mem_req;
  logic                w_mem_we;
  logic [WIDTH-1:0]    w_mem_addr;
  logic [WIDTH-1:0]    w_mem_wdata;
  logic                w_set_pc;

  // Decode helpers
  logic                w_is_ctype;
  logic                w_a_bit;
  logic [WIDTH-1:0]    w_a_imm;
  logic [WIDTH-1:0]    w_y_sel;
  logic [PC_WIDTH-1:0] w_jump_target;
  logic                w_r_neg;
  logic                w_r_zero;
  logic                w_r_pos;
  logic                w_jump_taken;
  logic                w_illegal_instr;

  assign w_is_ctype    = ir_q[15];
  assign w_a_bit       = ir_q[12];
  assign w_a_imm       = ir_q & c_BIT15_CLR;
  assign w_y_sel       = w_a_bit ? mdr_q : cu_bus.reg_a_in;
  assign w_jump_target = PC_WIDTH'(acap_q);

  // Result sign classification for the jump condition (R treated as signed)
  assign w_r_neg      = r_q[WIDTH-1];
  assign w_r_zero     = (r_q == '0);
  assign w_r_pos      = !w_r_neg && !w_r_zero;
  assign w_jump_taken = (ir_q[2] && w_r_neg) || (ir_q[1] && w_r_zero) || (ir_q[0] && w_r_pos);

`ifdef ILLEGAL_TRAP_EN
  logic r_illegal_q;
  logic w_trap;

  assign w_illegal_instr = w_is_ctype && (ir_q[14:13] != 2'b11);
  assign w_trap          = (state_q == c_DECODE) && w_illegal_instr;

  // Sticky illegal-instruction flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal_q <= 1'b0;
    end else if (w_trap) begin
      r_illegal_q <= 1'b1;
    end
  end

  assign cu_bus.illegal = r_illegal_q;
`else
  assign w_illegal_instr = 1'b0;
  assign cu_bus.illegal  = 1'b0;
`endif

  // Next-state and output decode for the instruction sequencer
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    mdr_d       = mdr_q;
    acap_d      = acap_q;
    r_d         = r_q;
    xh_d        = xh_q;
    yh_d        = yh_q;
    w_instr_req = 1'b0;
    w_x         = '0;
    w_y         = '0;
    w_opcode    = '0;
    w_reg_a_en  = 1'b0;
    w_reg_d_en  = 1'b0;
    w_reg_wdata = '0;
    w_mem_req   = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    w_set_pc    = 1'b0;

    case (state_q)
      c_FETCH: begin
        // run_q keeps instr_req low until the first clock after reset release
        w_instr_req = run_q;
        if (run_q && cu_bus.instr_valid) begin
          ir_d    = cu_bus.instr;
          state_d = c_DECODE;
        end
      end

      c_DECODE: begin
        if (!w_is_ctype) begin
          // A-type: load the immediate into A and move on
          w_reg_a_en  = 1'b1;
          w_reg_wdata = w_a_imm;
          pc_d        = pc_q + c_PC_ONE;
          state_d     = c_FETCH;
        end else if (w_illegal_instr) begin
          // Trapped word: no register or memory side effects
          w_set_pc = 1'b1;
          pc_d     = TRAP_VEC;
          state_d  = c_FETCH;
        end else begin
          // A is captured here so jump target and M address ignore any A write in WB
          acap_d = cu_bus.reg_a_in;
          if (w_a_bit) begin
            w_mem_req  = 1'b1;
            w_mem_addr = cu_bus.reg_a_in;
            state_d    = c_MEM_RD;
          end else begin
            state_d = c_EXEC;
          end
        end
      end

      c_MEM_RD: begin
        w_mem_req  = 1'b1;
        w_mem_addr = acap_q;
        if (cu_bus.mem_ready) begin
          mdr_d   = cu_bus.mem_rdata;
          state_d = c_EXEC;
        end
      end

      c_EXEC: begin
        w_x      = cu_bus.reg_d_in;
        w_y      = w_y_sel;
        w_opcode = ir_q[12:6];
        xh_d     = cu_bus.reg_d_in;
        yh_d     = w_y_sel;
        r_d      = cu_bus.alu_result;
        state_d  = c_WB;
      end

      c_WB: begin
        w_x         = xh_q;
        w_y         = yh_q;
        w_opcode    = ir_q[12:6];
        w_reg_wdata = r_q;
        w_reg_a_en  = ir_q[5];
        w_reg_d_en  = ir_q[4];
        if (w_jump_taken) begin
          w_set_pc = 1'b1;
          pc_d     = w_jump_target;
        end else begin
          pc_d = pc_q + c_PC_ONE;
        end
        if (ir_q[3]) begin
          w_mem_req   = 1'b1;
          w_mem_we    = 1'b1;
          w_mem_addr  = acap_q;
          w_mem_wdata = r_q;
          state_d     = c_MEM_WR;
        end else begin
          state_d = c_FETCH;
        end
      end

      c_MEM_WR: begin
        w_mem_req   = 1'b1;
        w_mem_we    = 1'b1;
        w_mem_addr  = acap_q;
        w_mem_wdata = r_q;
        if (cu_bus.mem_ready) begin
          state_d = c_FETCH;
        end
      end

      default: begin
        state_d = c_FETCH;
      end
    endcase
  end

  // Sequencer state and datapath latches; reset drops any in-flight request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= c_FETCH;
      run_q   <= 1'b0;
      pc_q    <= '0;
      ir_q    <= '0;
      mdr_q   <= '0;
      acap_q  <= '0;
      r_q     <= '0;
      xh_q    <= '0;
      yh_q    <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      mdr_q   <= mdr_d;
      acap_q  <= acap_d;
      r_q     <= r_d;
      xh_q    <= xh_d;
      yh_q    <= yh_d;
    end
  end

  assign cu_bus.instr_req  = w_instr_req;
  assign cu_bus.pc         = pc_q;
  assign cu_bus.x          = w_x;
  assign cu_bus.y          = w_y;
  assign cu_bus.opcode     = w_opcode;
  assign cu_bus.instr_type = ir_q[15];
  assign cu_bus.reg_a_en   = w_reg_a_en;
  assign cu_bus.reg_d_en   = w_reg_d_en;
  assign cu_bus.reg_wdata  = w_reg_wdata;
  assign cu_bus.mem_req    = w_mem_req;
  assign cu_bus.mem_we     = w_mem_we;
  assign cu_bus.mem_addr   = w_mem_addr;
  assign cu_bus.mem_wdata  = w_mem_wdata;
  assign cu_bus.set_pc     = w_set_pc;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_multicycle_control_unit                                      |
// | Brief    : Self-checking bench: memories, A/D registers and ALU around    |
// |            the control unit, with an instruction-level reference model.  |
// | Revision : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module tb_multicycle_control_unit;

  localparam int          W    = 16;
  localparam int          PW   = 16;
  localparam logic [15:0] TRAP = 16'h0040;
`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP_ON = 1'b1;
`else
  localparam bit TRAP_ON = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  multicycle_control_unit_if #(.WIDTH(W), .PC_WIDTH(PW)) bus ();

  multicycle_control_unit #(.WIDTH(W), .PC_WIDTH(PW), .TRAP_VEC(TRAP)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cu_bus (bus)
  );

  always #5 clk = ~clk;

  // Environment: A/D registers, 16-word data memory, Hack-style ALU
  logic [15:0] ra   = 16'h0;
  logic [15:0] rdr  = 16'h0;
  logic [15:0] dmem [16] = '{default: 16'h0};
  int          rd_dly = 1;
  int          wr_dly = 1;
  int          req_cyc = 0;

  function automatic logic [15:0] alu(input logic [15:0] xv, input logic [15:0] yv,
                                      input logic [5:0] c);
    logic [15:0] a, b, o;
    a = c[5] ? 16'h0 : xv;
    if (c[4]) a = ~a;
    b = c[3] ? 16'h0 : yv;
    if (c[2]) b = ~b;
    o = c[1] ? (a + b) : (a & b);
    if (c[0]) o = ~o;
    return o;
  endfunction

  assign bus.reg_a_in   = ra;
  assign bus.reg_d_in   = rdr;
  assign bus.mem_rdata  = dmem[bus.mem_addr[3:0]];
  assign bus.alu_result = alu(bus.x, bus.y, bus.opcode[5:0]);

  always @(posedge clk) begin
    if (bus.reg_a_en) ra  <= bus.reg_wdata;
    if (bus.reg_d_en) rdr <= bus.reg_wdata;
    if (bus.mem_req && bus.mem_we && bus.mem_ready) dmem[bus.mem_addr[3:0]] <= bus.mem_wdata;
  end

  // Data memory answers after the request has been up for the chosen delay
  always @(negedge clk) begin
    if (bus.mem_req) begin
      bus.mem_ready = (req_cyc >= (bus.mem_we ? wr_dly : rd_dly));
      req_cyc++;
    end else begin
      req_cyc       = 0;
      bus.mem_ready = 1'b0;
    end
  end

  // Reference model state
  logic [15:0] m_pc  = 16'h0;
  logic        m_ill = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, required 0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one instruction and compares every observable effect with the model
  task automatic exec(input logic [15:0] ins, input int fwait, input int rdl,
                      input int wrl, input string tag);
    logic [15:0] a0, d0, yv, r, pc_n, awd, dwd;
    logic        a_en, d_en, spc, rd_m, wr_m, taken, ill_n;
    logic [15:0] ex_x, ex_y;
    logic [6:0]  ex_op;
    int          ex_cyc;
    int          na, nd, ns, nrc, nwc, cyc, n;
    logic [15:0] oaw, odw, orad, owad, owd, ox, oy;
    logic [6:0]  oop;
    logic        rbad, wbad;

    a0 = ra; d0 = rdr;
    pc_n = m_pc + 16'd1;
    a_en = 0; d_en = 0; spc = 0; rd_m = 0; wr_m = 0; ill_n = m_ill;
    awd = 16'h0; dwd = 16'h0; r = 16'h0;
    ex_x = 16'h0; ex_y = 16'h0; ex_op = 7'h0; ex_cyc = 2;
    if (!ins[15]) begin
      a_en = 1; awd = {1'b0, ins[14:0]};
    end else if (TRAP_ON && ins[14:13] != 2'b11) begin
      spc = 1; pc_n = TRAP; ill_n = 1'b1;
    end else begin
      rd_m  = ins[12];
      yv    = rd_m ? dmem[a0[3:0]] : a0;
      r     = alu(d0, yv, ins[11:6]);
      ex_x  = d0; ex_y = yv; ex_op = ins[12:6];
      a_en  = ins[5]; d_en = ins[4]; awd = r; dwd = r;
      taken = (ins[2] && $signed(r) < 0) || (ins[1] && r == 16'h0) || (ins[0] && $signed(r) > 0);
      if (taken) begin spc = 1; pc_n = a0; end
      wr_m   = ins[3];
      ex_cyc = 4 + (rd_m ? rdl : 0) + (wr_m ? wrl : 0);
    end

    rd_dly = rdl; wr_dly = wrl;
    n = 0;
    while (!bus.instr_req && n < 30) begin @(negedge clk); n++; end
    chk({tag, " instr_req"}, bus.instr_req, 1);
    chk({tag, " pc start"}, bus.pc, m_pc);
    for (int i = 0; i < fwait; i++) begin
      bus.instr = 16'($urandom); bus.instr_valid = 1'b0;
      @(negedge clk);
      chk({tag, " req hold"}, bus.instr_req, 1);
    end
    bus.instr = ins; bus.instr_valid = 1'b1;

    na = 0; nd = 0; ns = 0; nrc = 0; nwc = 0; cyc = 1; rbad = 0; wbad = 0;
    oaw = 0; odw = 0; orad = 0; owad = 0; owd = 0; ox = 0; oy = 0; oop = 0;
    while (cyc < 60) begin
      @(negedge clk);
      bus.instr = 16'($urandom);
      if (bus.instr_req) begin bus.instr_valid = 1'b0; break; end
      bus.instr_valid = 1'($urandom_range(0, 1));
      if (bus.reg_a_en) begin na++; oaw = bus.reg_wdata; end
      if (bus.reg_d_en) begin nd++; odw = bus.reg_wdata; end
      if (bus.set_pc) ns++;
      if (bus.mem_req && !bus.mem_we) begin
        if (nrc == 0) orad = bus.mem_addr; else if (bus.mem_addr != orad) rbad = 1;
        nrc++;
      end
      if (bus.mem_req && bus.mem_we) begin
        if (nwc == 0) begin owad = bus.mem_addr; owd = bus.mem_wdata; end
        else if (bus.mem_addr != owad || bus.mem_wdata != owd) wbad = 1;
        nwc++;
      end
      if ((bus.x | bus.y | 16'(bus.opcode)) != 16'h0) begin
        ox = bus.x; oy = bus.y; oop = bus.opcode;
      end
      cyc++;
    end

    chk({tag, " cycles"}, cyc, ex_cyc);
    chk({tag, " a_en count"}, na, a_en);
    chk({tag, " d_en count"}, nd, d_en);
    if (a_en) chk({tag, " A wdata"}, oaw, awd);
    if (d_en) chk({tag, " D wdata"}, odw, dwd);
    chk({tag, " set_pc count"}, ns, spc);
    chk({tag, " pc end"}, bus.pc, pc_n);
    chk({tag, " rd req cycles"}, nrc, rd_m ? rdl + 1 : 0);
    chk({tag, " wr req cycles"}, nwc, wr_m ? wrl + 1 : 0);
    if (rd_m) chk({tag, " rd addr"}, {rbad, orad}, {1'b0, a0});
    if (wr_m) chk({tag, " wr addr"}, {wbad, owad}, {1'b0, a0});
    if (wr_m) chk({tag, " wr data"}, owd, r);
    chk({tag, " x"}, ox, ex_x);
    chk({tag, " y"}, oy, ex_y);
    chk({tag, " opcode"}, oop, ex_op);
    chk({tag, " illegal"}, bus.illegal, ill_n);
    m_pc = pc_n; m_ill = ill_n;
  endtask

  initial begin
    bus.instr = 16'h0; bus.instr_valid = 1'b0;
    #2;
    chk("reset instr_req", bus.instr_req, 0);
    chk("reset pc", bus.pc, 0);
    chk("reset mem_req", bus.mem_req, 0);
    chk("reset illegal", bus.illegal, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // A-type load and pc increment
    exec(16'h0003, 0, 1, 1, "t2 A=3");
    // D=3, A=2, D=D+A
    exec(16'hEC10, 0, 1, 1, "t3 D=A");
    exec(16'h0002, 1, 1, 1, "t3 A=2");
    exec(16'hE090, 0, 1, 1, "t3 D=D+A");
    // M[2]=4 then D=3, M=D+M with late memory
    exec(16'h0004, 0, 1, 1, "t4 A=4");
    exec(16'hEC10, 0, 1, 1, "t4 D=A");
    exec(16'h0002, 0, 1, 1, "t4 A=2");
    exec(16'hE308, 0, 1, 1, "t4 M=D");
    exec(16'h0003, 0, 1, 1, "t4 A=3");
    exec(16'hEC10, 0, 1, 1, "t4 D=A b");
    exec(16'h0002, 0, 1, 1, "t4 A=2 b");
    exec(16'hF088, 2, 4, 4, "t4 M=D+M");
    // Jumps on a negative result, then pc wrap
    exec(16'h0005, 0, 1, 1, "t5 A=5");
    exec(16'hECD0, 0, 1, 1, "t5 D=-A");
    exec(16'h0002, 0, 1, 1, "t5 A=2");
    exec(16'hE304, 0, 1, 1, "t5 D;JLT");
    exec(16'hE301, 0, 1, 1, "t5 D;JGT");
    exec(16'hEEA0, 0, 1, 1, "t5 A=-1");
    exec(16'hEA82, 0, 1, 1, "t5 0;JEQ");
    exec(16'h0001, 0, 1, 1, "t5 wrap");
    // Undefined C-type prefix
    exec(16'h8000, 0, 1, 1, "t6 8000");

    // Reset while a data read is still waiting for mem_ready
    rd_dly = 40;
    for (int n = 0; n < 30 && !bus.instr_req; n++) @(negedge clk);
    bus.instr = 16'hFC10; bus.instr_valid = 1'b1;
    @(negedge clk); bus.instr_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("t1 mem_req before rst", bus.mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t1 mem_req in rst", bus.mem_req, 0);
    chk("t1 pc in rst", bus.pc, 0);
    chk("t1 instr_req in rst", bus.instr_req, 0);
    chk("t1 strobes in rst", {bus.reg_a_en, bus.reg_d_en, bus.set_pc, bus.mem_we}, 0);
    chk("t1 x/y in rst", {bus.x, bus.y}, 0);
    chk("t1 illegal in rst", bus.illegal, 0);
    @(negedge clk);
    chk("t1 mem_req held rst", bus.mem_req, 0);
    #2 rst_n = 1'b1;
    m_pc = 16'h0; m_ill = 1'b0; rd_dly = 1;
    exec(16'h0007, 0, 1, 1, "t1 after rst");

    // Randomized instruction stream
    for (int i = 0; i < 40; i++) begin
      logic [15:0] ins;
      if ($urandom_range(0, 3) == 0) begin
        ins = {1'b0, 15'($urandom)};
      end else begin
        ins = 16'($urandom);
        ins[15] = 1'b1;
        if ($urandom_range(0, 5) != 0) ins[14:13] = 2'b11;
      end
      exec(ins, $urandom_range(0, 2), $urandom_range(1, 3), $urandom_range(1, 3), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
